// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one byte-strobed write port,
// optional hardwired-zero entry, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   rd_addr1,
  output logic [DATA_WIDTH-1:0]   rd_data1,
  input  logic [ADDR_WIDTH-1:0]   rd_addr2,
  output logic [DATA_WIDTH-1:0]   rd_data2,
  input  logic                    clear_req,
  output logic                    clear_busy
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]   mem      [NUM_REGS];
  logic [DATA_WIDTH-1:0]   mem_next [NUM_REGS];
  logic [DATA_WIDTH-1:0]   stored1;
  logic [DATA_WIDTH-1:0]   stored2;
  logic                    wr_valid;

  // Index names a real, writable/readable entry (not out of range, not the hardwired zero).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] base,
                                                  input logic [DATA_WIDTH-1:0] data,
                                                  input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) r[8*k +: 8] = data[8*k +: 8];
    end
    return r;
  endfunction

  assign wr_valid   = wr_en && in_range(wr_addr);
  assign clear_busy = (state == CLEAR);

  // The sweep zero is applied first so a same-cycle user write keeps only its enabled bytes.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_next[i] = mem[i];
      if ((state == CLEAR) && (int'(idx) == i)) mem_next[i] = '0;
      if (wr_valid && (int'(wr_addr) == i)) mem_next[i] = merge(mem_next[i], wr_data, wr_be);
    end
  end

  // Bypass merges over the stored value, never over the pending sweep zero.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_addr1) == i) stored1 = mem[i];
      if (int'(rd_addr2) == i) stored2 = mem[i];
    end
    rd_data1 = in_range(rd_addr1) ? stored1 : '0;
    rd_data2 = in_range(rd_addr2) ? stored2 : '0;
    if ((BYPASS != 0) && wr_valid && (wr_addr == rd_addr1))
      rd_data1 = merge(stored1, wr_data, wr_be);
    if ((BYPASS != 0) && wr_valid && (wr_addr == rd_addr2))
      rd_data2 = merge(stored2, wr_data, wr_be);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      state <= IDLE;
      idx   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= mem_next[i];
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            idx   <= (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
          end
        end
        CLEAR: begin
          idx <= idx + ADDR_WIDTH'(1);
          if (int'(idx) == NUM_REGS - 1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (16 regs/zero-reg/bypass and 12 regs/plain/no-bypass)
// share stimulus and are checked against an array-and-queue reference model.
module tb_regfile_param;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int BW  = 4;
  localparam int N_A = 16;
  localparam int N_B = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_be;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          clear_req;
  logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic          a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl_a [32];
  logic [DW-1:0] mdl_b [32];
  int            q_a[$];
  int            q_b[$];

  always #5 clk = ~clk;

  regfile_param #(.DATA_WIDTH(DW), .NUM_REGS(N_A), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr1(rd_addr1), .rd_data1(a_rd1), .rd_addr2(rd_addr2), .rd_data2(a_rd2),
    .clear_req(clear_req), .clear_busy(a_busy));

  regfile_param #(.DATA_WIDTH(DW), .NUM_REGS(N_B), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr1(rd_addr1), .rd_data1(b_rd1), .rd_addr2(rd_addr2), .rd_data2(b_rd2),
    .clear_req(clear_req), .clear_busy(b_busy));

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < BW; k++) if (be[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  function automatic logic [DW-1:0] written(input logic [DW-1:0] old);
    return (old & ~be_mask(wr_be)) | (wr_data & be_mask(wr_be));
  endfunction

  function automatic logic [DW-1:0] exp_a(input logic [AW-1:0] a);
    int ai;
    logic [DW-1:0] v;
    ai = int'(a);
    if (ai >= N_A || ai == 0) return '0;
    v = mdl_a[ai];
    if (wr_en && wr_addr == a) v = written(v);
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_b(input logic [AW-1:0] a);
    if (int'(a) >= N_B) return '0;
    return mdl_b[int'(a)];
  endfunction

  task automatic tick();
    int wa;
    @(posedge clk);
    wa = int'(wr_addr);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mdl_a[i] = '0;
        mdl_b[i] = '0;
      end
      q_a.delete();
      q_b.delete();
    end else begin
      if (q_a.size() > 0) mdl_a[q_a.pop_front()] = '0;
      else if (clear_req) for (int i = 1; i < N_A; i++) q_a.push_back(i);
      if (q_b.size() > 0) mdl_b[q_b.pop_front()] = '0;
      else if (clear_req) for (int i = 0; i < N_B; i++) q_b.push_back(i);
      if (wr_en && wa > 0 && wa < N_A) mdl_a[wa] = written(mdl_a[wa]);
      if (wr_en && wa < N_B) mdl_b[wa] = written(mdl_b[wa]);
    end
    #1;
  endtask

  task automatic drive(input logic en, input int wa, input logic [DW-1:0] d, input logic [BW-1:0] be,
                       input int ra1, input int ra2, input logic creq);
    wr_en     = en;
    wr_addr   = AW'(wa);
    wr_data   = d;
    wr_be     = be;
    rd_addr1  = AW'(ra1);
    rd_addr2  = AW'(ra2);
    clear_req = creq;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4, 32'hA5A5A5A5, 4'hF, 0, 0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 0, '0, '0, a, 31 - a, 1'b0);
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy a=%0b b=%0b exp 0", a_busy, b_busy);
      end
      checks++;
      if (a_rd1 !== '0 || a_rd2 !== '0 || b_rd1 !== '0 || b_rd2 !== '0) begin
        errors++;
        $display("FAIL reset_zero addr=%0d got %h %h %h %h exp 0", a, a_rd1, a_rd2, b_rd1, b_rd2);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0);
    tick();
    drive(1'b0, 0, '0, '0, 3, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (a_rd1 !== 32'hDEADBEEF || b_rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_entry3 a=%h b=%h exp deadbeef", a_rd1, b_rd1);
    end
    checks++;
    if (a_rd2 !== '0 || b_rd2 !== exp_b(0)) begin
      errors++;
      $display("FAIL wr_rd_entry0 a=%h b=%h exp 0 %h", a_rd2, b_rd2, exp_b(0));
    end
    tick();
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 5, 32'h11223344, 4'hF, 5, 5, 1'b0);
    tick();
    drive(1'b1, 5, 32'hAABBCCDD, 4'b0101, 5, 5, 1'b0);
    tick();
    drive(1'b0, 0, '0, '0, 5, 5, 1'b0);
    @(negedge clk);
    checks++;
    if (a_rd1 !== 32'h11BB33DD || b_rd1 !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_merge a=%h b=%h exp 11bb33dd", a_rd1, b_rd1);
    end
    drive(1'b1, 5, 32'hFFFFFFFF, 4'h0, 5, 5, 1'b0);
    @(negedge clk);
    checks++;
    if (a_rd1 !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_zero_bypass a=%h exp 11bb33dd", a_rd1);
    end
    tick();
    drive(1'b0, 0, '0, '0, 5, 5, 1'b0);
    @(negedge clk);
    checks++;
    if (a_rd2 !== 32'h11BB33DD || b_rd2 !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_zero_hold a=%h b=%h exp 11bb33dd", a_rd2, b_rd2);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 7, 32'h0, 4'hF, 0, 0, 1'b0);
    tick();
    drive(1'b1, 7, 32'h12345678, 4'hF, 7, 7, 1'b0);
    @(negedge clk);
    checks++;
    if (a_rd1 !== 32'h12345678 || a_rd2 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_on rd1=%h rd2=%h exp 12345678", a_rd1, a_rd2);
    end
    checks++;
    if (b_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL bypass_off got=%h exp 0", b_rd1);
    end
    tick();
    drive(1'b0, 0, '0, '0, 7, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (b_rd1 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_off_next got=%h exp 12345678", b_rd1);
    end
    tick();
  endtask

  task automatic test_invalid();
    drive(1'b1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (a_rd1 !== '0) begin
      errors++;
      $display("FAIL zero_reg_bypass got=%h exp 0", a_rd1);
    end
    tick();
    drive(1'b1, 13, 32'hCAFEF00D, 4'hF, 13, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (b_rd1 !== '0 || a_rd1 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL oob_read b=%h exp 0 a=%h exp cafef00d", b_rd1, a_rd1);
    end
    checks++;
    if (a_rd2 !== '0 || b_rd2 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL entry0 a=%h exp 0 b=%h exp ffffffff", a_rd2, b_rd2);
    end
    tick();
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 0, '0, '0, a, a + 16, 1'b0);
      @(negedge clk);
      checks++;
      if (a_rd1 !== exp_a(rd_addr1) || b_rd1 !== exp_b(rd_addr1) ||
          a_rd2 !== exp_a(rd_addr2) || b_rd2 !== exp_b(rd_addr2)) begin
        errors++;
        $display("FAIL invalid_state addr=%0d a=%h/%h b=%h/%h exp %h/%h %h/%h", a, a_rd1, a_rd2,
                 b_rd1, b_rd2, exp_a(rd_addr1), exp_a(rd_addr2), exp_b(rd_addr1), exp_b(rd_addr2));
      end
      tick();
    end
  endtask

  task automatic test_clear();
    int cnt_a = 0;
    int cnt_b = 0;
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, i, DW'(i), 4'hF, 0, 0, 1'b0);
      tick();
    end
    drive(1'b0, 0, '0, '0, 0, 0, 1'b1);
    tick();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 0, '0, '0, $urandom_range(0, 17), $urandom_range(0, 17), c == 5);
      if (c == 1) drive(1'b1, 2, 32'h55, 4'hF, 2, 3, 1'b0);
      @(negedge clk);
      if (a_busy) cnt_a++;
      if (b_busy) cnt_b++;
      checks++;
      if (a_busy !== (q_a.size() != 0) || b_busy !== (q_b.size() != 0)) begin
        errors++;
        $display("FAIL clear_busy cyc=%0d a=%0b b=%0b exp %0b %0b", c, a_busy, b_busy,
                 q_a.size() != 0, q_b.size() != 0);
      end
      checks++;
      if (a_rd1 !== exp_a(rd_addr1) || a_rd2 !== exp_a(rd_addr2) ||
          b_rd1 !== exp_b(rd_addr1) || b_rd2 !== exp_b(rd_addr2)) begin
        errors++;
        $display("FAIL clear_read cyc=%0d a=%h/%h b=%h/%h exp %h/%h %h/%h", c, a_rd1, a_rd2,
                 b_rd1, b_rd2, exp_a(rd_addr1), exp_a(rd_addr2), exp_b(rd_addr1), exp_b(rd_addr2));
      end
      tick();
    end
    checks++;
    if (cnt_a != 15 || cnt_b != 12) begin
      errors++;
      $display("FAIL clear_len a=%0d exp 15 b=%0d exp 12", cnt_a, cnt_b);
    end
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 0, '0, '0, a, a, 1'b0);
      @(negedge clk);
      checks++;
      if (a_rd1 !== ((a == 2) ? 32'h55 : 32'h0) || b_rd1 !== '0) begin
        errors++;
        $display("FAIL clear_after addr=%0d a=%h b=%h", a, a_rd1, b_rd1);
      end
      tick();
    end
  endtask

  task automatic test_clear_reset();
    for (int i = 8; i < 12; i++) begin
      drive(1'b1, i, 32'hF0F0_0000 | DW'(i), 4'hF, 0, 0, 1'b0);
      tick();
    end
    drive(1'b0, 0, '0, '0, 0, 0, 1'b1);
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_rst_busy a=%0b b=%0b exp 0", a_busy, b_busy);
    end
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 0, '0, '0, a, a, 1'b0);
      #1;
      checks++;
      if (a_rd1 !== '0 || b_rd1 !== '0) begin
        errors++;
        $display("FAIL clear_rst_zero addr=%0d a=%h b=%h exp 0", a, a_rd1, b_rd1);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
            : $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 29) == 0);
      @(negedge clk);
      checks++;
      if (a_busy !== (q_a.size() != 0) || b_busy !== (q_b.size() != 0)) begin
        errors++;
        $display("FAIL rand_busy cyc=%0d a=%0b b=%0b", c, a_busy, b_busy);
      end
      checks++;
      if (a_rd1 !== exp_a(rd_addr1) || a_rd2 !== exp_a(rd_addr2) ||
          b_rd1 !== exp_b(rd_addr1) || b_rd2 !== exp_b(rd_addr2)) begin
        errors++;
        $display("FAIL rand_read cyc=%0d a=%h/%h b=%h/%h exp %h/%h %h/%h", c, a_rd1, a_rd2,
                 b_rd1, b_rd2, exp_a(rd_addr1), exp_a(rd_addr2), exp_b(rd_addr1), exp_b(rd_addr2));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, '0, '0, 0, 0, 1'b0);
    test_reset();
    test_write_read();
    test_byte_enable();
    test_bypass();
    test_invalid();
    test_clear();
    test_clear_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
